video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_SYNC, default 96: horizontal sync width, pixels.
REQ-002 Parameter H_BACK, default 48: horizontal back porch, pixels.
REQ-003 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-004 Parameter H_FRONT, default 16: horizontal front porch, pixels.
REQ-005 Parameters V_SYNC, V_BACK, V_ACTIVE, V_FRONT, defaults 2, 33, 480, 10: vertical equivalents, lines.
REQ-006 Parameter REQ_LEAD, default 1, legal 0..H_BACK: cycles by which req leads the active window.
REQ-007 Parameters HS_POL and VS_POL, default 0: asserted level of hs and vs.
REQ-008 Parameter CW, default 13: counter, col and row width.
REQ-009 Port clk, input, 1: pixel clock; all logic is on the rising edge.
REQ-010 Port reset, input, 1: synchronous, active-high reset.
REQ-011 Port en, input, 1: pixel advance enable; when low, all state holds.
REQ-012 Port ext_vs, input, 1: external frame-start reference (camera VS); used only under VTG_SOF_LOCK_EN.
REQ-013 Ports hs and vs, output, 1 each: sync outputs, registered.
REQ-014 Port blank_n, output, 1: high inside the active region.
REQ-015 Port req, output, 1: pixel-data request, REQ_LEAD cycles ahead of blank_n.
REQ-016 Ports col and row, output, CW each: active-region coordinates; 0 outside the active region.
REQ-017 Ports sof and eol, output, 1 each: single-cycle start-of-frame and end-of-active-line pulses.
REQ-018 Port frame_cnt, output, 8: count of completed frames, wrapping.

Function
REQ-019 H_TOTAL is the sum of the four H parameters, and V_TOTAL the sum of the four V parameters; both are localparams.
REQ-020 h_cnt runs 0..H_TOTAL-1 and advances by 1 on each en cycle; on wrap to 0, v_cnt advances 0..V_TOTAL-1.
REQ-021 Each axis shall be tracked by a 4-state FSM: SYNC, BACK, ACTIVE, FRONT, entered at counter values 0, SYNC, SYNC+BACK and SYNC+BACK+ACTIVE respectively; FRONT returns to SYNC on wrap.
REQ-022 All outputs shall be registered and decoded from next-state counters, so they align with the counter value they describe, with zero added latency.
REQ-023 hs shall equal HS_POL while the H FSM is in SYNC, and vs shall equal VS_POL while the V FSM is in SYNC; otherwise each shall be the inverse polarity.
REQ-024 blank_n shall be 1 only when both FSMs are in ACTIVE.
REQ-025 col shall equal h_cnt-(H_SYNC+H_BACK) and row shall equal v_cnt-(V_SYNC+V_BACK) when blank_n is 1.
REQ-026 req shall be 1 when v is ACTIVE and h_cnt is in [H_SYNC+H_BACK-REQ_LEAD, H_SYNC+H_BACK+H_ACTIVE-REQ_LEAD-1].
REQ-027 sof shall pulse for one en cycle at h_cnt=0, v_cnt=0; frame_cnt shall increment in the same cycle, 255 wrapping to 0.
REQ-028 eol shall pulse on the last active pixel of each active line.
REQ-029 When en is low, outputs hold, and sof/eol held high stay high until the next en cycle.

Reset
REQ-030 Reset shall force h_cnt=0, v_cnt=0, both FSMs to SYNC, hs=HS_POL, vs=VS_POL, blank_n=0, req=0, col=0, row=0, sof=0, eol=0, frame_cnt=0.
REQ-031 Reset shall take priority over en and ext_vs; reset mid-frame shall restart timing at (0,0) on the first cycle after release, with no sof pulse for that cycle.

Configuration
REQ-032 Macro VTG_SOF_LOCK_EN defined: a registered rising edge on ext_vs, detected on an en cycle, shall force the next counter state to (0,0), pulse sof and increment frame_cnt once.
REQ-033 An ext_vs edge coinciding with a natural wrap shall produce exactly one sof and one frame_cnt increment.
REQ-034 Macro VTG_SOF_LOCK_EN undefined: ext_vs shall be ignored and its edge-detect register shall not exist.

Structure
REQ-035 Default timing constants, the axis FSM state typedef (SYNC, BACK, ACTIVE, FRONT) and the frame_cnt width shall live in shared package video_timing_pkg.
REQ-036 One sub-module, vtg_axis_counter, shall be instantiated twice (H and V); it holds one counter, its FSM and a wrap/advance handshake.

Verification
REQ-037 Defaults, en=1, run 2 frames -> 800 cycles per line, 525 lines per frame, hs low for h_cnt 0..95, vs low for lines 0..1, 307200 blank_n cycles per frame.
REQ-038 REQ_LEAD=1 -> req rises at h_cnt=143, blank_n rises at 144 with col=0, last col=639 coincides with eol, and req falls one cycle before blank_n.
REQ-039 en toggled 1/0 every cycle -> line period is 1600 clk cycles, outputs are identical to the en=1 run when sampled on en cycles, and sof is held through the en-low cycle.
REQ-040 Reset asserted at v_cnt=200, h_cnt=300 for 3 cycles -> all outputs take reset values, and counting restarts at (0,0) after release.
REQ-041 VTG_SOF_LOCK_EN defined, ext_vs edge at v_cnt=100 -> next en cycle is (0,0) with sof=1 and frame_cnt+1; an edge at the natural wrap gives a single increment.
REQ-042 frame_cnt at 255 plus one frame -> frame_cnt=0 together with sof.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared timing defaults, axis state encoding and frame counter width for
// the video timing generator and its axis counters.
package video_timing_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_CW       = 13;
  localparam int FRAME_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BACK   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FRONT  = 2'd3
  } axis_state_e;

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One timing axis: a 0..TOTAL-1 counter plus its SYNC/BACK/ACTIVE/FRONT FSM.
// Next-state values are exported so the parent can register outputs with no lag.
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter int SYNC_W   = DEF_H_SYNC,
  parameter int BACK_W   = DEF_H_BACK,
  parameter int ACTIVE_W = DEF_H_ACTIVE,
  parameter int TOTAL    = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv_i,
  input  logic          load_zero_i,
  output logic [CW-1:0] cnt_d_o,
  output axis_state_e   state_d_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
  localparam logic [CW-1:0] BACK_AT   = CW'(SYNC_W);
  localparam logic [CW-1:0] ACTIVE_AT = CW'(SYNC_W + BACK_W);
  localparam logic [CW-1:0] FRONT_AT  = CW'(SYNC_W + BACK_W + ACTIVE_W);

  logic [CW-1:0] cnt_q, cnt_d;
  axis_state_e   state_q, state_d;

  // Handshake: adv_i is a one-cycle advance request; wrap_o is high in the
  // same cycle when that advance takes the counter from LAST back to 0, and
  // serves as the advance request of the next-slower axis.
  always_comb begin
    wrap_o  = adv_i && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (load_zero_i || wrap_o) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
    end

    state_d = state_q;
    if (cnt_d == '0) begin
      state_d = ST_SYNC;
    end else if (cnt_d == BACK_AT) begin
      state_d = ST_BACK;
    end else if (cnt_d == ACTIVE_AT) begin
      state_d = ST_ACTIVE;
    end else if (cnt_d == FRONT_AT) begin
      state_d = ST_FRONT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= ST_SYNC;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign cnt_d_o   = cnt_d;
  assign state_d_o = state_d;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, blanking, pixel request and coordinates.
// Define VTG_SOF_LOCK_EN to let a rising edge on ext_vs restart the frame.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int REQ_LEAD = 1,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = DEF_CW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   ext_vs,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank_n,
  output logic                   req,
  output logic [CW-1:0]          col,
  output logic [CW-1:0]          row,
  output logic                   sof,
  output logic                   eol,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] REQ_FIRST   = CW'(H_SYNC + H_BACK - REQ_LEAD);
  localparam logic [CW-1:0] REQ_LAST    = CW'(H_SYNC + H_BACK + H_ACTIVE - REQ_LEAD - 1);

  logic [CW-1:0] h_cnt_d, v_cnt_d;
  axis_state_e   h_state_d, v_state_d;
  logic          h_wrap, v_wrap, sof_lock;

  logic                   hs_q, vs_q, blank_n_q, req_q, sof_q, eol_q;
  logic                   hs_d, vs_d, blank_n_d, req_d, sof_d, eol_d;
  logic [CW-1:0]          col_q, row_q, col_d, row_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

`ifdef VTG_SOF_LOCK_EN
  logic ext_vs_q;

  // The edge register only moves on en cycles, so an edge arriving while
  // en is low is still seen on the next en cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_vs_q <= 1'b0;
    end else if (en) begin
      ext_vs_q <= ext_vs;
    end
  end

  assign sof_lock = en && ext_vs && !ext_vs_q;
`else
  logic unused_ext_vs;
  assign unused_ext_vs = ext_vs;
  assign sof_lock      = 1'b0;
`endif

  vtg_axis_counter #(
    .SYNC_W   (H_SYNC),
    .BACK_W   (H_BACK),
    .ACTIVE_W (H_ACTIVE),
    .TOTAL    (H_TOTAL),
    .CW       (CW)
  ) u_h_axis (
    .clk         (clk),
    .reset       (reset),
    .adv_i       (en),
    .load_zero_i (sof_lock),
    .cnt_d_o     (h_cnt_d),
    .state_d_o   (h_state_d),
    .wrap_o      (h_wrap)
  );

  vtg_axis_counter #(
    .SYNC_W   (V_SYNC),
    .BACK_W   (V_BACK),
    .ACTIVE_W (V_ACTIVE),
    .TOTAL    (V_TOTAL),
    .CW       (CW)
  ) u_v_axis (
    .clk         (clk),
    .reset       (reset),
    .adv_i       (h_wrap),
    .load_zero_i (sof_lock),
    .cnt_d_o     (v_cnt_d),
    .state_d_o   (v_state_d),
    .wrap_o      (v_wrap)
  );

  always_comb begin
    hs_d        = (h_state_d == ST_SYNC) ? HS_POL : ~HS_POL;
    vs_d        = (v_state_d == ST_SYNC) ? VS_POL : ~VS_POL;
    blank_n_d   = (h_state_d == ST_ACTIVE) && (v_state_d == ST_ACTIVE);
    col_d       = blank_n_d ? (h_cnt_d - H_ACT_START) : '0;
    row_d       = blank_n_d ? (v_cnt_d - V_ACT_START) : '0;
    req_d       = (v_state_d == ST_ACTIVE) && (h_cnt_d >= REQ_FIRST) && (h_cnt_d <= REQ_LAST);
    eol_d       = blank_n_d && (h_cnt_d == H_ACT_LAST);
    // A lock coinciding with a natural frame wrap still yields one pulse.
    sof_d       = v_wrap || sof_lock;
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(sof_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q        <= HS_POL;
      vs_q        <= VS_POL;
      blank_n_q   <= 1'b0;
      req_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else if (en) begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_n_q   <= blank_n_d;
      req_q       <= req_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hs        = hs_q;
  assign vs        = vs_q;
  assign blank_n   = blank_n_q;
  assign req       = req_q;
  assign col       = col_q;
  assign row       = row_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster (17 x 10) so whole frames
// and a full frame_cnt wrap fit in a short run.
module tb_video_timing_gen;

  localparam int H_SYNC = 4, H_BACK = 3, H_ACTIVE = 8, H_FRONT = 2;
  localparam int V_SYNC = 2, V_BACK = 2, V_ACTIVE = 5, V_FRONT = 1;
  localparam int REQ_LEAD = 2;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int CW = 8;
  localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          blank_n;
    logic          req;
    logic          sof;
    logic          eol;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [7:0]    frame;
  } obs_t;
  localparam int OW = $bits(obs_t);

  logic          clk, reset, en, ext_vs;
  logic          hs, vs, blank_n, req, sof, eol;
  logic [CW-1:0] col, row;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  // Model state: linear raster position, sof flag and frame count.
  int pos     = 0;
  int m_frame = 0;
  bit m_sof   = 1'b0;
  bit ext_prev = 1'b0;

  video_timing_gen #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
    .REQ_LEAD(REQ_LEAD), .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ext_vs(ext_vs),
    .hs(hs), .vs(vs), .blank_n(blank_n), .req(req),
    .col(col), .row(row), .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
  );

  // ---- clock / reset ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t model_out(input int p, input bit s, input int f);
    obs_t o;
    int h, v;
    bit hact, vact;
    h    = p % HT;
    v    = p / HT;
    hact = (h >= H_SYNC + H_BACK) && (h < H_SYNC + H_BACK + H_ACTIVE);
    vact = (v >= V_SYNC + V_BACK) && (v < V_SYNC + V_BACK + V_ACTIVE);
    o.hs      = (h < H_SYNC) ? HS_POL : !HS_POL;
    o.vs      = (v < V_SYNC) ? VS_POL : !VS_POL;
    o.blank_n = hact && vact;
    o.col     = o.blank_n ? CW'(h - (H_SYNC + H_BACK)) : '0;
    o.row     = o.blank_n ? CW'(v - (V_SYNC + V_BACK)) : '0;
    o.req     = vact && (h >= H_SYNC + H_BACK - REQ_LEAD) &&
                (h <= H_SYNC + H_BACK + H_ACTIVE - REQ_LEAD - 1);
    o.sof     = s;
    o.eol     = o.blank_n && (h == H_SYNC + H_BACK + H_ACTIVE - 1);
    o.frame   = 8'(f);
    return o;
  endfunction

  // ---- reference model: advances with the DUT clock ----
  always @(posedge clk) begin
    bit lock;
    lock = 1'b0;
    if (reset) begin
      pos = 0; m_frame = 0; m_sof = 1'b0; ext_prev = 1'b0;
    end else if (en) begin
`ifdef VTG_SOF_LOCK_EN
      lock     = ext_vs && !ext_prev;
      ext_prev = ext_vs;
`endif
      pos   = lock ? 0 : (pos + 1) % FT;
      m_sof = (pos == 0);
      if (m_sof) m_frame = (m_frame + 1) % 256;
    end
    exp_q.push_back(model_out(pos, m_sof, m_frame));
  end

  // ---- scoreboard: every cycle, away from the active edge ----
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hs", hs, e.hs);
      check("vs", vs, e.vs);
      check("blank_n", blank_n, e.blank_n);
      check("req", req, e.req);
      check("sof", sof, e.sof);
      check("eol", eol, e.eol);
      check("col", col, e.col);
      check("row", row, e.row);
      check("frame_cnt", frame_cnt, e.frame);
    end
  end

  // ---- driver tasks ----
  task automatic do_reset(input int n, input logic en_val);
    @(negedge clk);
    reset = 1'b1; en = en_val; ext_vs = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0; en = 1'b0;
  endtask

  initial begin
    int first_req, first_blank, nsof, nblank, nhs, nvs, nreq, neol, col_at_eol;
    int sof_a, sof_b;
    reset = 1'b1; en = 1'b0; ext_vs = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hs", hs, HS_POL);
    check("rst_vs", vs, VS_POL);
    check("rst_blank_n", blank_n, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b0;

    // Two frames with en held high; ext_vs pulses are ignored without the lock.
    first_req = -1; first_blank = -1; nsof = 0; nblank = 0; nhs = 0; nvs = 0;
    nreq = 0; neol = 0; col_at_eol = -1;
    for (int i = 0; i <= 2 * FT; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (req && first_req < 0) first_req = i;
        if (blank_n && first_blank < 0) first_blank = i;
        if (sof) nsof++;
        if (blank_n) nblank++;
        if (hs == HS_POL) nhs++;
        if (vs == VS_POL) nvs++;
        if (req) nreq++;
        if (eol) begin neol++; col_at_eol = col; end
      end
      en = 1'b1;
`ifndef VTG_SOF_LOCK_EN
      ext_vs = (i >= 50 && i < 60);
`endif
    end
    check("first_req_cycle", first_req, 73);
    check("first_blank_cycle", first_blank, 75);
    check("sof_count_2frames", nsof, 2);
    check("blank_cycles_2frames", nblank, 80);
    check("hs_active_cycles", nhs, 80);
    check("vs_active_cycles", nvs, 68);
    check("req_cycles_2frames", nreq, 80);
    check("eol_count_2frames", neol, 10);
    check("col_at_eol", col_at_eol, 7);
    check("frame_cnt_after_2", frame_cnt, 2);
    ext_vs = 1'b0;

    // en toggling every cycle: frame period doubles, sof held over en-low.
    do_reset(3, 1'b0);
    nsof = 0; sof_a = -1; sof_b = -1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (sof) begin
        nsof++;
        if (sof_a < 0) sof_a = i;
        else if (i > sof_a + 1 && sof_b < 0) sof_b = i;
      end
      en = (i % 2 == 0);
    end
    check("toggle_sof_samples", nsof, 4);
    check("toggle_first_sof", sof_a, 339);
    check("toggle_frame_period", sof_b - sof_a, 2 * FT);

    // Mid-frame reset with en high at v=5, h=10 (inside the active window).
    do_reset(3, 1'b0);
    for (int i = 0; i <= 95; i++) begin
      @(negedge clk);
      en = 1'b1;
    end
    check("pre_rst_blank_n", blank_n, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_col", col, 0);
    check("mid_rst_row", row, 0);
    check("mid_rst_req", req, 0);
    check("mid_rst_sof", sof, 0);
    reset = 1'b0;
    sof_a = -1;
    for (int i = 0; i <= FT; i++) begin
      @(negedge clk);
      if (i == 0) check("post_rst_no_sof", sof, 0);
      if (sof && sof_a < 0) sof_a = i;
    end
    check("post_rst_first_sof", sof_a, FT - 1);

    // frame_cnt wrap after 256 frames.
    do_reset(3, 1'b0);
    for (int i = 0; i <= 256 * FT; i++) begin
      @(negedge clk);
      if (i == 256 * FT - 1) check("frame_cnt_255", frame_cnt, 255);
      if (i == 256 * FT) begin
        check("frame_cnt_wrap", frame_cnt, 0);
        check("frame_wrap_sof", sof, 1);
      end
      en = 1'b1;
    end

`ifdef VTG_SOF_LOCK_EN
    // ext_vs edge mid-frame, then an edge coinciding with the natural wrap.
    do_reset(3, 1'b0);
    for (int i = 0; i <= 260; i++) begin
      @(negedge clk);
      if (i == 89) begin
        check("lock_sof", sof, 1);
        check("lock_frame", frame_cnt, 1);
        check("lock_hs", hs, HS_POL);
        check("lock_vs", vs, VS_POL);
      end
      if (i == 258) check("prewrap_sof", sof, 0);
      if (i == 259) begin
        check("wrap_lock_sof", sof, 1);
        check("wrap_lock_frame", frame_cnt, 2);
      end
      if (i == 260) check("wrap_lock_single", frame_cnt, 2);
      en = 1'b1;
      ext_vs = (i == 88) || (i == 258);
    end
    ext_vs = 1'b0;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
